// File: rtl/branch_pkg.sv
// branch_pkg: types and constants shared by the fetch-side branch predictor
// and the execute-stage branch comparator.
//   ctr_t             2-bit saturating direction counter state
//   F3_*              B-type funct3 encodings (BEQ..BGEU)
//   ctr_is_taken()    direction implied by a counter state
package branch_pkg;

  // The encoding is architectural: bit 1 is the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic ctr_is_taken(input ctr_t ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// sat_counter2: combinational next state of a 2-bit saturating counter.
//   ctr_i    current counter state
//   taken_i  resolved branch outcome
//   ctr_o    next counter state (steps toward ST on taken, SNT on not-taken)
module sat_counter2
  import branch_pkg::*;
(
  input  ctr_t ctr_i,
  input  logic taken_i,
  output ctr_t ctr_o
);

  // NOTE: default-assign every always_comb output first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    ctr_o = ctr_i;
    case (ctr_i)
      SNT:     ctr_o = taken_i ? WNT : SNT;
      WNT:     ctr_o = taken_i ? WT  : SNT;
      WT:      ctr_o = taken_i ? ST  : WNT;
      ST:      ctr_o = taken_i ? ST  : WT;
      default: ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters.
//   clk, rst                  clock and synchronous active-high reset
//   fetch_pc                  PC being fetched
//   pred_hit/_taken/_target   same-cycle prediction from the registered table
//   upd_valid, upd_pc,        resolved branch presented for training,
//   upd_taken, upd_target,    with the prediction that was made for it
//   upd_pred_taken/_target
//   mispredict, redirect_pc   redirect request and correct next PC
//   mispredict_count          saturating count of mispredict cycles
module branch_predictor
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     mispredict_count
);

  localparam int              IDX     = $clog2(ENTRIES);
  localparam int              TAG_W   = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Field widths depend on this instance's parameters, so the entry type
  // lives here rather than in the shared package.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    ctr_t             ctr;
  } btb_entry_t;

  btb_entry_t btb_q [ENTRIES];
  btb_entry_t btb_d [ENTRIES];
  logic [31:0] mispredict_count_q, mispredict_count_d;

  logic [IDX-1:0]   fetch_idx, upd_idx;
  logic [TAG_W-1:0] fetch_tag, upd_tag;
  btb_entry_t       fetch_entry, upd_entry;
  logic             upd_hit;
  ctr_t             ctr_next;

  assign fetch_idx   = fetch_pc[IDX+1:2];
  assign fetch_tag   = fetch_pc[XLEN-1:IDX+2];
  assign upd_idx     = upd_pc[IDX+1:2];
  assign upd_tag     = upd_pc[XLEN-1:IDX+2];
  assign fetch_entry = btb_q[fetch_idx];
  assign upd_entry   = btb_q[upd_idx];
  assign upd_hit     = upd_entry.valid && (upd_entry.tag == upd_tag);

  sat_counter2 u_ctr (
    .ctr_i   (upd_entry.ctr),
    .taken_i (upd_taken),
    .ctr_o   (ctr_next)
  );

  // Prediction reads the registered table only: a same-cycle update to the
  // same index is not bypassed. rst masks the table while it is being cleared.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = fetch_pc + PC_STEP;
    if (!rst && fetch_entry.valid && (fetch_entry.tag == fetch_tag)) begin
      pred_hit   = 1'b1;
      pred_taken = ctr_is_taken(fetch_entry.ctr);
      if (pred_taken) pred_target = fetch_entry.target;
    end
  end

  always_comb begin
    mispredict  = !rst && upd_valid &&
                  ((upd_taken != upd_pred_taken) ||
                   (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
    redirect_pc = (!rst && upd_taken) ? upd_target : upd_pc + PC_STEP;
  end

  // Training: a hit steps the counter (target refreshed only when taken);
  // a taken miss allocates over whatever held the index; a not-taken miss
  // leaves the table alone.
  always_comb begin
    btb_d = btb_q;
    if (upd_valid) begin
      if (upd_hit) begin
        btb_d[upd_idx].ctr = ctr_next;
        if (upd_taken) btb_d[upd_idx].target = upd_target;
      end else if (upd_taken) begin
        btb_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: WT};
      end
    end
  end

  always_comb begin
    mispredict_count_d = mispredict_count_q;
    if (mispredict && (mispredict_count_q != 32'hFFFF_FFFF))
      mispredict_count_d = mispredict_count_q + 32'd1;
  end

  // NOTE: the table is built from flops, not RAM, so every entry can and must
  // be cleared by reset; a RAM-inferred table could not be reset this way.
  // NOTE: sequential state is written with non-blocking assignments so all
  // flops sample their _d values from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
      mispredict_count_q <= '0;
    end else begin
      btb_q              <= btb_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int ENT = 16;
  localparam int IDX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] mispredict_count;

  int checks = 0;
  int failures = 0;

  // Behavioural model: per-index valid/tag/target and an integer confidence 0..3.
  bit          m_valid [ENT];
  logic [31:0] m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_ctr   [ENT];
  longint      m_cnt;

  branch_predictor #(.ENTRIES(ENT), .XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc >> (IDX + 2);
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_cnt = 0;
  endfunction

  function automatic void m_predict(input logic [31:0] pc, input bit in_rst,
                                    output bit hit, output bit tk, output logic [31:0] tgt);
    int i = m_idx(pc);
    hit = !in_rst && m_valid[i] && (m_tag[i] == m_tagof(pc));
    tk  = hit && (m_ctr[i] >= 2);
    tgt = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  // A mispredict is a wrong direction, or a taken branch whose predicted
  // next PC differs from the actual next PC.
  function automatic bit m_mis();
    logic [31:0] pred_next, act_next;
    if (rst || !upd_valid) return 0;
    pred_next = upd_pred_taken ? upd_pred_target : upd_pc + 32'd4;
    act_next  = upd_taken ? upd_target : upd_pc + 32'd4;
    return (upd_taken != upd_pred_taken) || (pred_next != act_next);
  endfunction

  function automatic void m_train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    int i = m_idx(pc);
    if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[i] = 1; m_tag[i] = m_tagof(pc); m_tgt[i] = tgt; m_ctr[i] = 2;
    end
  endfunction

  task automatic drive(input logic [31:0] fpc, input bit uv, input logic [31:0] upc,
                       input bit ut, input logic [31:0] utgt,
                       input bit upt, input logic [31:0] uptgt);
    fetch_pc = fpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
    #1;
  endtask

  task automatic idle(input logic [31:0] fpc);
    drive(fpc, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  // Advance one clock, moving the model with the inputs held across the edge.
  task automatic tick();
    bit mis = m_mis();
    @(posedge clk);
    if (rst) m_clear();
    else begin
      if (upd_valid) m_train(upd_pc, upd_taken, upd_target);
      if (mis && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h0);
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL rst_hit got=%0b exp=0", pred_hit); end
    checks++; if (pred_target !== 32'h104) begin failures++; $display("FAIL rst_target got=%h exp=104", pred_target); end
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL rst_mispredict got=%0b exp=0", mispredict); end
    checks++; if (redirect_pc !== 32'h104) begin failures++; $display("FAIL rst_redirect got=%h exp=104", redirect_pc); end
    tick(); tick();
    rst = 0;
    idle(32'h100);
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL post_rst_hit got=%0b exp=0", pred_hit); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL post_rst_taken got=%0b exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin failures++; $display("FAIL post_rst_target got=%h exp=104", pred_target); end
    checks++; if (mispredict_count !== 32'h0) begin failures++; $display("FAIL post_rst_count got=%h exp=0", mispredict_count); end
  endtask

  task automatic test_alloc();
    drive(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h0);
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL alloc_mispredict got=%0b exp=1", mispredict); end
    checks++; if (redirect_pc !== 32'h80) begin failures++; $display("FAIL alloc_redirect got=%h exp=80", redirect_pc); end
    tick();
    idle(32'h100);
    checks++; if ({pred_hit, pred_taken} !== 2'b11) begin failures++; $display("FAIL alloc_pred got=%b exp=11", {pred_hit, pred_taken}); end
    checks++; if (pred_target !== 32'h80) begin failures++; $display("FAIL alloc_target got=%h exp=80", pred_target); end
    checks++; if (mispredict_count !== 32'd1) begin failures++; $display("FAIL alloc_count got=%0d exp=1", mispredict_count); end
  endtask

  task automatic test_training();
    for (int k = 0; k < 3; k++) begin
      drive(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80);
      checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL train_taken_mis got=%0b exp=0", mispredict); end
      tick();
    end
    drive(32'h100, 1, 32'h100, 0, 32'h0, 1, 32'h80);
    checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h104) begin
      failures++; $display("FAIL train_nt_redirect got=%0b/%h exp=1/104", mispredict, redirect_pc); end
    tick();
    idle(32'h100);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      failures++; $display("FAIL train_wt got=%0b/%h exp=1/80", pred_taken, pred_target); end
    drive(32'h100, 1, 32'h100, 0, 32'h0, 1, 32'h80);
    tick();
    idle(32'h100);
    checks++; if ({pred_hit, pred_taken} !== 2'b10 || pred_target !== 32'h104) begin
      failures++; $display("FAIL train_wnt got=%b/%h exp=10/104", {pred_hit, pred_taken}, pred_target); end
  endtask

  task automatic test_alias();
    drive(32'h0, 1, 32'h100, 1, 32'h80, 0, 32'h0);
    tick();
    drive(32'h0, 1, 32'h140, 1, 32'h200, 0, 32'h0);
    tick();
    idle(32'h100);
    checks++; if (pred_hit !== 1'b0 || pred_target !== 32'h104) begin
      failures++; $display("FAIL alias_evicted got=%0b/%h exp=0/104", pred_hit, pred_target); end
    idle(32'h140);
    checks++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      failures++; $display("FAIL alias_new got=%0b%0b/%h exp=11/200", pred_hit, pred_taken, pred_target); end
  endtask

  task automatic test_same_cycle();
    drive(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h84);
    checks++; if (pred_hit !== 1'b0 || pred_target !== 32'h104) begin
      failures++; $display("FAIL same_old_pred got=%0b/%h exp=0/104", pred_hit, pred_target); end
    checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin
      failures++; $display("FAIL same_target_mis got=%0b/%h exp=1/80", mispredict, redirect_pc); end
    tick();
    idle(32'h100);
    checks++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      failures++; $display("FAIL same_new_pred got=%0b%0b/%h exp=11/80", pred_hit, pred_taken, pred_target); end
  endtask

  task automatic test_saturation();
    idle(32'h0);
    force dut.mispredict_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.mispredict_count_q;
    m_cnt = 64'hFFFF_FFFE;
    checks++; if (mispredict_count !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL sat_preload got=%h exp=fffffffe", mispredict_count); end
    for (int k = 0; k < 3; k++) begin
      drive(32'h0, 1, 32'h300, 0, 32'h0, 1, 32'h400);
      tick();
      checks++; if (mispredict_count !== 32'hFFFF_FFFF) begin
        failures++; $display("FAIL sat_count step=%0d got=%h exp=ffffffff", k, mispredict_count); end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1;
    drive(32'h500, 1, 32'h500, 1, 32'h600, 0, 32'h0);
    checks++; if (mispredict !== 1'b0 || pred_hit !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs got=%0b/%0b exp=0/0", mispredict, pred_hit); end
    tick();
    rst = 0;
    idle(32'h500);
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL midrst_no_alloc got=%0b exp=0", pred_hit); end
    idle(32'h140);
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL midrst_cleared got=%0b exp=0", pred_hit); end
    checks++; if (mispredict_count !== 32'h0) begin failures++; $display("FAIL midrst_count got=%h exp=0", mispredict_count); end
  endtask

  function automatic logic [31:0] pick_pc();
    int r = int'($urandom_range(0, 9));
    if (r < 6) return 32'h100 + 32'(r % 3) * 32'h40 + 32'(r / 3) * 32'h4;
    if (r == 9) return 32'hFFFF_FFFC;
    return $urandom;
  endfunction

  task automatic test_random();
    bit e_hit, e_tk, p_hit, p_tk;
    logic [31:0] e_tgt, p_tgt, upc, utgt, e_red;
    bit e_mis;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      upc  = pick_pc();
      utgt = $urandom & 32'hFFFF_FFFC;
      m_predict(upc, 1'b0, p_hit, p_tk, p_tgt);
      if ($urandom_range(0, 3) == 0) p_tk = ~p_tk;
      if ($urandom_range(0, 3) == 0) p_tgt = $urandom;
      drive(pick_pc(), $urandom_range(0, 3) != 0, upc, $urandom_range(0, 1) == 1, utgt, p_tk, p_tgt);
      m_predict(fetch_pc, rst, e_hit, e_tk, e_tgt);
      e_mis = m_mis();
      e_red = (!rst && upd_taken) ? upd_target : upd_pc + 32'd4;
      checks++; if (pred_hit !== e_hit || pred_taken !== e_tk || pred_target !== e_tgt) begin
        failures++; $display("FAIL rnd_pred n=%0d pc=%h got=%0b%0b/%h exp=%0b%0b/%h",
                             n, fetch_pc, pred_hit, pred_taken, pred_target, e_hit, e_tk, e_tgt); end
      checks++; if (mispredict !== e_mis || redirect_pc !== e_red) begin
        failures++; $display("FAIL rnd_resolve n=%0d got=%0b/%h exp=%0b/%h",
                             n, mispredict, redirect_pc, e_mis, e_red); end
      if (!rst) begin
        checks++; if (mispredict_count !== m_cnt[31:0]) begin
          failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, mispredict_count, m_cnt); end
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    m_clear();
    test_reset();
    test_alloc();
    test_training();
    test_alias();
    test_same_cycle();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
